instr_stream_encoder: RTL and testbench
=======================================

# instr_stream_encoder

Encodes high-level operation requests (kind, registers, immediate, function fields) into 32-bit RV32I instruction words and writes them sequentially into the pipeline's instruction memory. It is the inverse of the opcode decoder: each request class maps to exactly one opcode recognised by the decode stage (R-type, I-type ALU, LW, SW, branch, JAL, JALR). It sits between the bench or boot logic and the instruction-memory write port. After the program it pads NOPs so the pipeline drains cleanly.

## Interface
- ADDR_W, 9, instruction-memory word-address width; capacity 2^ADDR_W words
- PAD_NOPS, 4, NOP words appended after `fin`
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_kind  in  3  0 R, 1 I-ALU, 2 LW, 3 SW, 4 BR, 5 JAL, 6 JALR, 7 illegal
- req_funct3  in  3  funct3 (forced 000 for JALR)
- req_funct7  in  7  funct7 (R only)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  21  signed immediate
- fin  in  1  single-cycle pulse: program complete, start padding
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded word
- full  out  1  address space exhausted
- err  out  1  sticky: an illegal or out-of-range request was dropped
- done  out  1  padding finished; held until reset

## Operation
- States: RUN, PAD, DONE. Reset → RUN, internal address counter 0.
- RUN: req_ready = !full. A handshake encodes the request and registers mem_we=1, mem_wdata, mem_addr=counter, then counter+1.
- Encodings (opcode in [6:0]):
  - R: funct7|rs2|rs1|f3|rd|0110011
  - I: imm[11:0]|rs1|f3|rd|0010011
  - LW: imm[11:0]|rs1|f3|rd|0000011
  - SW: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011
  - BR: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111
  - JALR: imm[11:0]|rs1|000|rd|1100111
- Kind 7: request consumed, no write, err set, counter unchanged.
- full: set when the counter wraps past 2^ADDR_W−1 after a write. No wrap-around overwrite; req_ready stays low.
- fin in RUN: go to PAD. A handshake in the same cycle is still written first.
- PAD: req_ready=0. Write 0x00000013 PAD_NOPS times, one per cycle. Stop early if full. Then DONE.
- DONE: req_ready=0, mem_we=0, done=1. fin is ignored.
- fin outside RUN is ignored.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, full=0, err=0, done=0. req_ready=1 in the cycle after reset deasserts.
- Latency: a handshake in cycle N gives mem_we/addr/wdata valid in cycle N+1, held for exactly one cycle.
- Throughput: one word per cycle, no bubbles.
- Reset mid-program or mid-pad: aborts immediately. Counter returns to 0; memory contents are not cleared.
- PAD: first NOP one cycle after the fin cycle (or after the final request, if concurrent). done rises the cycle after the last NOP.

## Configuration
- ENCODER_RANGE_CHECK_EN defined:
  - I, LW, SW, JALR: imm must fit 12-bit signed.
  - BR: imm must fit 13-bit signed and be even.
  - JAL: imm must fit 21-bit signed and be even.
  - A violation drops the request (consumed, not written) and sets err.
- Undefined: immediates are silently truncated and bit 0 is ignored. err is set only by kind 7.

## Test plan
- R add: rd=3, rs1=1, rs2=2, f3=0, f7=0 → next cycle mem_we=1, addr 0, wdata 0x002081B3.
- Back-to-back requests:
  - addi x1,x0,5 → 0x00500093 at addr 0
  - sw x2,8(x1) (f3=2) → 0x0020A423 at addr 1
  - beq x1,x2,−8 → 0xFE208CE3 at addr 2
  - jal x1,16 → 0x010000EF at addr 3
  - Writes in four consecutive cycles.
- fin after 2 words → four writes of 0x00000013 at addrs 2..5, then done=1 and req_ready=0.
- ADDR_W=2, five requests → four writes, then full=1 and req_ready=0. The fifth request is not accepted.
- With ENCODER_RANGE_CHECK_EN:
  - addi imm=2048 → no write, err=1.
  - Next valid request is written at the unchanged address.
  - Without the macro, the same request writes 0x80000093.
- Reset asserted during PAD after 2 NOPs → the cycle after reset, all outputs are at reset values. The next request writes at addr 0.

Source files
------------

// File: rtl/instr_stream_encoder_if.sv
// instr_stream_encoder_if: request bus from the program source and the
// instruction-memory write / status bus of the encoder.
// master = program source (bench or boot logic), slave = encoder.
interface instr_stream_encoder_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [2:0]        req_funct3;
  logic [6:0]        req_funct7;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [20:0]       req_imm;
  logic              fin;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              full;
  logic              err;
  logic              done;

  modport master (
    output req_valid, req_kind, req_funct3, req_funct7,
           req_rd, req_rs1, req_rs2, req_imm, fin,
    input  req_ready, mem_we, mem_addr, mem_wdata, full, err, done
  );

  modport slave (
    input  req_valid, req_kind, req_funct3, req_funct7,
           req_rd, req_rs1, req_rs2, req_imm, fin,
    output req_ready, mem_we, mem_addr, mem_wdata, full, err, done
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: turns operation requests into RV32I instruction words
// and writes them sequentially into instruction memory, then appends
// PAD_NOPS NOPs (addi x0,x0,0) after 'fin' so the pipeline drains.
// Optional feature macro: ENCODER_RANGE_CHECK_EN -- when defined, requests
// whose immediate does not fit the target format (or is odd for BR/JAL) are
// dropped and flag err; when undefined, immediates are silently truncated.
module instr_stream_encoder #(
  parameter int ADDR_W   = 9,
  parameter int PAD_NOPS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  instr_stream_encoder_if.slave  bus
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int          PAD_W    = (PAD_NOPS < 1) ? 1 : $clog2(PAD_NOPS + 1);
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PAD_NOPS);

  localparam logic [2:0] K_R    = 3'd0;
  localparam logic [2:0] K_I    = 3'd1;
  localparam logic [2:0] K_LW   = 3'd2;
  localparam logic [2:0] K_SW   = 3'd3;
  localparam logic [2:0] K_BR   = 3'd4;
  localparam logic [2:0] K_JAL  = 3'd5;
  localparam logic [2:0] K_JALR = 3'd6;
  localparam logic [2:0] K_ILL  = 3'd7;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PAD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Assemble one instruction word from the request fields.
  function automatic logic [31:0] encode_word(
    input logic [2:0]  kind,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [20:0] imm
  );
    logic [31:0] w;
    case (kind)
      K_R:    w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      K_I:    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
      K_LW:   w = {imm[11:0], rs1, f3, rd, 7'b0000011};
      K_SW:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      K_BR:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      K_JAL:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      K_JALR: w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

`ifdef ENCODER_RANGE_CHECK_EN
  // True when the immediate is representable in the target format.
  function automatic logic imm_in_range(
    input logic [2:0]  kind,
    input logic [20:0] imm
  );
    logic ok;
    case (kind)
      K_I, K_LW, K_SW, K_JALR: ok = (imm[20:11] == {10{imm[11]}});
      K_BR:                    ok = (imm[20:12] == {9{imm[12]}}) && (imm[0] == 1'b0);
      K_JAL:                   ok = (imm[0] == 1'b0);
      default:                 ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [PAD_W-1:0]  r_pad_cnt;
  logic              r_full;
  logic              r_err;
  logic              r_done;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_imm_ok;
  logic              w_legal;
  logic [31:0]       w_enc;
  logic              w_ready;
  logic              w_hs;
  logic              w_wr_en;
  logic [31:0]       w_wr_data;
  logic              w_pad_inc;
  logic              w_set_err;
  logic              w_pad_left;

`ifdef ENCODER_RANGE_CHECK_EN
  assign w_imm_ok = imm_in_range(bus.req_kind, bus.req_imm);
`else
  assign w_imm_ok = 1'b1;
`endif

  assign w_legal    = (bus.req_kind != K_ILL) && w_imm_ok;
  assign w_enc      = encode_word(bus.req_kind, bus.req_funct3, bus.req_funct7,
                                  bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm);
  // NOP slots remain and there is still address space to put them in.
  assign w_pad_left = (!r_full) && (r_pad_cnt < PAD_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: fin leaves RUN, PAD ends when NOPs are spent or memory is full.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (bus.fin) begin
          w_state_nxt = S_PAD;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_PAD: begin
        if (!w_pad_left) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_PAD;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Output/action logic: handshake, write selection and NOP issue per state.
  // A lone fin in RUN already issues the first NOP so padding starts one
  // cycle after fin; a concurrent request takes that slot instead.
  always_comb begin
    w_ready   = 1'b0;
    w_hs      = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_data = NOP_WORD;
    w_pad_inc = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      S_RUN: begin
        w_ready = !r_full;
        w_hs    = bus.req_valid && !r_full;
        if (w_hs) begin
          if (w_legal) begin
            w_wr_en   = 1'b1;
            w_wr_data = w_enc;
          end else begin
            w_set_err = 1'b1;
          end
        end else if (bus.fin && w_pad_left) begin
          w_wr_en   = 1'b1;
          w_pad_inc = 1'b1;
        end else begin
          w_wr_en = 1'b0;
        end
      end
      S_PAD: begin
        if (w_pad_left) begin
          w_wr_en   = 1'b1;
          w_pad_inc = 1'b1;
        end else begin
          w_wr_en = 1'b0;
        end
      end
      S_DONE: begin
        w_wr_en = 1'b0;
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  // Datapath registers: write port, address counter, pad count and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt       <= {ADDR_W{1'b0}};
      r_pad_cnt   <= {PAD_W{1'b0}};
      r_full      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= 32'h0000_0000;
    end else begin
      r_mem_we <= w_wr_en;
      if (w_wr_en) begin
        r_mem_addr  <= r_cnt;
        r_mem_wdata <= w_wr_data;
        r_cnt       <= r_cnt + ADDR_W'(1);
        if (r_cnt == {ADDR_W{1'b1}}) begin
          r_full <= 1'b1;
        end else begin
          r_full <= r_full;
        end
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_pad_inc) begin
        r_pad_cnt <= r_pad_cnt + PAD_W'(1);
      end else begin
        r_pad_cnt <= r_pad_cnt;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
      if (w_state_nxt == S_DONE) begin
        r_done <= 1'b1;
      end else begin
        r_done <= r_done;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.full      = r_full;
  assign bus.err       = r_err;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb_instr_stream_encoder: self-checking bench for instr_stream_encoder.
// Expected words come from a field-arithmetic model of the RV32I formats.
module tb_instr_stream_encoder;
  localparam int AW  = 9;
  localparam int AWS = 2;
  localparam int NP  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  instr_stream_encoder_if #(.ADDR_W(AW))  bus   ();
  instr_stream_encoder_if #(.ADDR_W(AWS)) bus_s ();

  instr_stream_encoder #(.ADDR_W(AW), .PAD_NOPS(NP)) dut (
    .i_clk(clk), .i_reset(reset), .bus(bus.slave));
  instr_stream_encoder #(.ADDR_W(AWS), .PAD_NOPS(NP)) dut_s (
    .i_clk(clk), .i_reset(reset), .bus(bus_s.slave));

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference encoding from the instruction-format bit positions.
  function automatic logic [31:0] ref_word(int unsigned kind, int unsigned f3, int unsigned f7,
                                           int unsigned rd, int unsigned rs1, int unsigned rs2,
                                           int imm);
    logic [31:0] u;
    logic [31:0] w;
    u = imm;
    case (kind)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      2: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      3: w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((u & 32'h1F) << 7) | 32'h23;
      4: w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
             | (((u >> 11) & 32'h1) << 7) | 32'h63;
      5: w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
             | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
      6: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Whether a request of this kind/immediate gets written.
  function automatic bit ref_legal(int unsigned kind, int imm);
    if (kind == 7) return 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
    if (kind == 1 || kind == 2 || kind == 3 || kind == 6) return (imm >= -2048 && imm <= 2047);
    if (kind == 4) return (imm >= -4096 && imm <= 4095 && (imm % 2 == 0));
    if (kind == 5) return (imm % 2 == 0);
`endif
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0; bus.fin = 1'b0;
    bus.req_kind = 3'd0; bus.req_funct3 = 3'd0; bus.req_funct7 = 7'd0;
    bus.req_rd = 5'd0; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0; bus.req_imm = 21'd0;
  endtask

  task automatic set_req(int unsigned kind, int unsigned f3, int unsigned f7, int unsigned rd,
                         int unsigned rs1, int unsigned rs2, int imm);
    bus.req_valid  = 1'b1;
    bus.req_kind   = kind[2:0];
    bus.req_funct3 = f3[2:0];
    bus.req_funct7 = f7[6:0];
    bus.req_rd     = rd[4:0];
    bus.req_rs1    = rs1[4:0];
    bus.req_rs2    = rs2[4:0];
    bus.req_imm    = imm[20:0];
  endtask

  task automatic do_reset();
    idle();
    bus_s.req_valid = 1'b0; bus_s.fin = 1'b0;
    bus_s.req_kind = 3'd0; bus_s.req_funct3 = 3'd0; bus_s.req_funct7 = 7'd0;
    bus_s.req_rd = 5'd0; bus_s.req_rs1 = 5'd0; bus_s.req_rs2 = 5'd0; bus_s.req_imm = 21'd0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.full, bus.err, bus.done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%0b addr=%0d data=%08h full=%0b err=%0b done=%0b, want all 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.full, bus.err, bus.done);
    end
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %0b want 1", bus.req_ready);
    end
    vectors++;
    if ({bus_s.req_ready, bus_s.mem_we, bus_s.full} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_small: got ready/we/full=%03b want 100",
               {bus_s.req_ready, bus_s.mem_we, bus_s.full});
    end
  endtask

  task automatic test_r_add();
    do_reset();
    set_req(0, 0, 0, 3, 1, 2, 0);
    step();
    idle();
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 9'd0, 32'h002081B3}) begin
      miscompares++;
      $display("FAIL r_add: got we=%0b addr=%0d data=%08h want we=1 addr=0 data=002081b3",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    step();
    vectors++;
    if (bus.mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL r_add_one_cycle: got we=%0b want 0", bus.mem_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h00500093; exp_w[1] = 32'h0020A423;
    exp_w[2] = 32'hFE208CE3; exp_w[3] = 32'h010000EF;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_req(1, 0, 0, 1, 0, 0, 5);
        1: set_req(3, 2, 0, 0, 1, 2, 8);
        2: set_req(4, 0, 0, 0, 1, 2, -8);
        default: set_req(5, 0, 0, 1, 0, 0, 16);
      endcase
      step();
      vectors++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 9'(i), exp_w[i]}) begin
        miscompares++;
        $display("FAIL b2b_word%0d: got we=%0b addr=%0d data=%08h want we=1 addr=%0d data=%08h",
                 i, bus.mem_we, bus.mem_addr, bus.mem_wdata, i, exp_w[i]);
      end
    end
    idle();
  endtask

  task automatic test_fin_pad();
    do_reset();
    set_req(0, 0, 0, 5, 6, 7, 0); step();
    set_req(1, 0, 0, 4, 3, 0, 100); step();
    idle();
    bus.fin = 1'b1;
    for (int k = 0; k < NP; k++) begin
      step();
      bus.fin = 1'b0;
      vectors++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.req_ready} !== {1'b1, 9'(2 + k), 32'h13, 1'b0}) begin
        miscompares++;
        $display("FAIL pad_nop%0d: got we=%0b addr=%0d data=%08h ready=%0b want we=1 addr=%0d data=00000013 ready=0",
                 k, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.req_ready, 2 + k);
      end
    end
    step();
    vectors++;
    if ({bus.mem_we, bus.done, bus.req_ready} !== 3'b010) begin
      miscompares++;
      $display("FAIL pad_done: got we/done/ready=%03b want 010", {bus.mem_we, bus.done, bus.req_ready});
    end
    bus.fin = 1'b1; step(); bus.fin = 1'b0; step();
    vectors++;
    if ({bus.mem_we, bus.done, bus.req_ready} !== 3'b010) begin
      miscompares++;
      $display("FAIL done_fin_ignored: got we/done/ready=%03b want 010", {bus.mem_we, bus.done, bus.req_ready});
    end
  endtask

  task automatic test_fin_concurrent();
    do_reset();
    set_req(6, 5, 0, 1, 2, 0, 12);
    bus.fin = 1'b1;
    step();
    idle();
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 9'd0, ref_word(6, 5, 0, 1, 2, 0, 12)}) begin
      miscompares++;
      $display("FAIL fin_conc_req: got we=%0b addr=%0d data=%08h want we=1 addr=0 data=%08h",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, ref_word(6, 5, 0, 1, 2, 0, 12));
    end
    step();
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 9'd1, 32'h13}) begin
      miscompares++;
      $display("FAIL fin_conc_nop: got we=%0b addr=%0d data=%08h want we=1 addr=1 data=00000013",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus_s.req_valid = 1'b1; bus_s.req_kind = 3'd0; bus_s.req_funct3 = 3'd0;
      bus_s.req_funct7 = 7'd0; bus_s.req_rd = 5'(i); bus_s.req_rs1 = 5'd1;
      bus_s.req_rs2 = 5'd2; bus_s.req_imm = 21'd0;
      vectors++;
      if (bus_s.req_ready !== (i < 4)) begin
        miscompares++;
        $display("FAIL full_ready%0d: got %0b want %0b", i, bus_s.req_ready, (i < 4));
      end
      step();
      vectors++;
      if (i < 4) begin
        if ({bus_s.mem_we, bus_s.mem_addr, bus_s.mem_wdata, bus_s.full} !==
            {1'b1, 2'(i), ref_word(0, 0, 0, i, 1, 2, 0), (i == 3)}) begin
          miscompares++;
          $display("FAIL full_write%0d: got we=%0b addr=%0d data=%08h full=%0b want we=1 addr=%0d data=%08h full=%0b",
                   i, bus_s.mem_we, bus_s.mem_addr, bus_s.mem_wdata, bus_s.full,
                   i, ref_word(0, 0, 0, i, 1, 2, 0), (i == 3));
        end
      end else begin
        if ({bus_s.mem_we, bus_s.full} !== 2'b01) begin
          miscompares++;
          $display("FAIL full_fifth: got we/full=%02b want 01", {bus_s.mem_we, bus_s.full});
        end
      end
    end
    bus_s.req_valid = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    set_req(7, 0, 0, 1, 1, 1, 0); step();
    idle();
    vectors++;
    if ({bus.mem_we, bus.err} !== 2'b01) begin
      miscompares++;
      $display("FAIL illegal_kind: got we/err=%02b want 01", {bus.mem_we, bus.err});
    end
    set_req(0, 0, 32, 9, 8, 7, 0); step();
    idle();
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.err} !== {1'b1, 9'd0, ref_word(0, 0, 32, 9, 8, 7, 0), 1'b1}) begin
      miscompares++;
      $display("FAIL illegal_next: got we=%0b addr=%0d data=%08h err=%0b want we=1 addr=0 data=%08h err=1",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.err, ref_word(0, 0, 32, 9, 8, 7, 0));
    end
  endtask

  task automatic test_imm_range();
    do_reset();
    set_req(1, 0, 0, 1, 0, 0, 2048); step();
    idle();
`ifdef ENCODER_RANGE_CHECK_EN
    vectors++;
    if ({bus.mem_we, bus.err} !== 2'b01) begin
      miscompares++;
      $display("FAIL range_drop: got we/err=%02b want 01", {bus.mem_we, bus.err});
    end
    set_req(1, 0, 0, 1, 0, 0, 5); step();
    idle();
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 9'd0, 32'h00500093}) begin
      miscompares++;
      $display("FAIL range_next: got we=%0b addr=%0d data=%08h want we=1 addr=0 data=00500093",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
`else
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.err} !== {1'b1, 9'd0, 32'h80000093, 1'b0}) begin
      miscompares++;
      $display("FAIL range_trunc: got we=%0b addr=%0d data=%08h err=%0b want we=1 addr=0 data=80000093 err=0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.err);
    end
`endif
  endtask

  task automatic test_reset_mid_pad();
    do_reset();
    set_req(0, 0, 0, 1, 2, 3, 0); step();
    set_req(0, 0, 0, 4, 5, 6, 0); step();
    idle();
    bus.fin = 1'b1; step(); bus.fin = 1'b0; step();
    reset = 1'b1; step(); reset = 1'b0;
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.full, bus.err, bus.done, bus.req_ready} !==
        {1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL midpad_reset: got we=%0b addr=%0d data=%08h full=%0b err=%0b done=%0b ready=%0b want 0/0/0/0/0/0/1",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.full, bus.err, bus.done, bus.req_ready);
    end
    set_req(2, 2, 0, 7, 3, 0, -4); step();
    idle();
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 9'd0, ref_word(2, 2, 0, 7, 3, 0, -4)}) begin
      miscompares++;
      $display("FAIL midpad_restart: got we=%0b addr=%0d data=%08h want we=1 addr=0 data=%08h",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, ref_word(2, 2, 0, 7, 3, 0, -4));
    end
  endtask

  task automatic test_random();
    int unsigned kind, f3, f7, rd, rs1, rs2;
    int          imm;
    int          exp_cnt;
    bit          exp_err, hs, legal;
    do_reset();
    exp_cnt = 0;
    exp_err = 1'b0;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 7);
      f3 = $urandom_range(0, 7); f7 = $urandom_range(0, 127);
      rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 0) imm = int'($urandom_range(0, 4095)) - 2048;
      else imm = int'($urandom_range(0, 2097151)) - 1048576;
      hs = ($urandom_range(0, 9) < 7);
      if (hs) set_req(kind, f3, f7, rd, rs1, rs2, imm);
      else idle();
      vectors++;
      if (bus.req_ready !== (exp_cnt < (1 << AW))) begin
        miscompares++;
        $display("FAIL rand_ready%0d: got %0b want %0b", n, bus.req_ready, (exp_cnt < (1 << AW)));
      end
      hs = hs && (exp_cnt < (1 << AW));
      legal = ref_legal(kind, imm);
      step();
      vectors++;
      if (hs && legal) begin
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 9'(exp_cnt), ref_word(kind, f3, f7, rd, rs1, rs2, imm)}) begin
          miscompares++;
          $display("FAIL rand_write%0d: kind=%0d imm=%0d got we=%0b addr=%0d data=%08h want we=1 addr=%0d data=%08h",
                   n, kind, imm, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_cnt,
                   ref_word(kind, f3, f7, rd, rs1, rs2, imm));
        end
        exp_cnt++;
      end else begin
        if (hs) exp_err = 1'b1;
        if (bus.mem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_nowrite%0d: kind=%0d imm=%0d got we=%0b want 0", n, kind, imm, bus.mem_we);
        end
      end
      vectors++;
      if (bus.err !== exp_err) begin
        miscompares++;
        $display("FAIL rand_err%0d: got %0b want %0b", n, bus.err, exp_err);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_back_to_back();
    test_fin_pad();
    test_fin_concurrent();
    test_full();
    test_illegal();
    test_imm_range();
    test_reset_mid_pad();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
